hamming_decoder_pipe: RTL

Pipelined SECDED decoder for the 8/4 Hamming code produced by the team's encoder table. It accepts one 8-bit codeword per cycle over a valid/ready handshake and delivers the 4-bit message with corrected/uncorrectable flags two cycles later. It also keeps saturating error-statistics counters, and sits between the channel receive path and the message consumer.

---
 rtl/hamming_decoder_pipe.sv | 105 ++++++++++
 1 files changed

// File: rtl/hamming_decoder_pipe.sv
// Two-stage SECDED decoder for the affine 8/4 Hamming code, with saturating
// corrected/uncorrectable counters on the output handshake.
module hamming_decoder_pipe #(
  parameter int CNT_W = 8
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic [7:0]       cw,
  input  logic             cw_valid,
  output logic             cw_ready,
  output logic [3:0]       msg,
  output logic             err_corr,
  output logic             err_uncorr,
  output logic             msg_valid,
  input  logic             msg_ready,
  input  logic             clr_counts,
  output logic [CNT_W-1:0] corr_count,
  output logic [CNT_W-1:0] uncorr_count
);

  typedef struct packed {
    logic [3:0] msg;
    logic       corr;
    logic       uncorr;
  } dec_t;

  logic       s1_valid, s2_valid;
  logic [7:0] s1_cw;
  logic [3:0] s1_syn, syn;
  logic [3:0] raw;
  dec_t       dec, s2;
  logic       adv2, out_hs;

  // The inverted parity terms make the all-zero message encode to 8'h15.
  assign syn[3] =   cw[6] ^ cw[7] ^ cw[5] ^ cw[3];
  assign syn[2] = ~(cw[4] ^ cw[5] ^ cw[3] ^ cw[1]);
  assign syn[1] = ~(cw[2] ^ cw[7] ^ cw[3] ^ cw[1]);
  assign syn[0] = ~(cw[0] ^ cw[7] ^ cw[5] ^ cw[1]);

  assign adv2     = !s2_valid || msg_ready;
  assign cw_ready = !s1_valid || !s2_valid || msg_ready;
  assign out_hs   = s2_valid && msg_ready;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      s1_valid <= 1'b0;
      s1_cw    <= '0;
      s1_syn   <= '0;
    end else if (cw_ready) begin
      s1_valid <= cw_valid;
      s1_cw    <= cw;
      s1_syn   <= syn;
    end
  end

  assign raw = {s1_cw[7], s1_cw[5], s1_cw[3], s1_cw[1]};

  // Odd syndromes are single errors (weight 3 names a data bit); even nonzero
  // syndromes are double errors and pass the raw data through.
  always_comb begin
    dec.msg    = raw;
    dec.corr   = 1'b0;
    dec.uncorr = 1'b0;
    case (s1_syn)
      4'b0000: ;
      4'b1000, 4'b0100, 4'b0010, 4'b0001: dec.corr = 1'b1;
      4'b1011: begin dec.corr = 1'b1; dec.msg = raw ^ 4'b1000; end
      4'b1101: begin dec.corr = 1'b1; dec.msg = raw ^ 4'b0100; end
      4'b1110: begin dec.corr = 1'b1; dec.msg = raw ^ 4'b0010; end
      4'b0111: begin dec.corr = 1'b1; dec.msg = raw ^ 4'b0001; end
      default: dec.uncorr = 1'b1;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      s2_valid <= 1'b0;
      s2       <= '0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      s2       <= dec;
    end
  end

  assign msg_valid  = s2_valid;
  assign msg        = s2.msg;
  assign err_corr   = s2.corr;
  assign err_uncorr = s2.uncorr;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      corr_count   <= '0;
      uncorr_count <= '0;
    end else if (clr_counts) begin
      corr_count   <= '0;
      uncorr_count <= '0;
    end else if (out_hs) begin
      if (s2.corr && (corr_count != {CNT_W{1'b1}}))
        corr_count <= corr_count + CNT_W'(1);
      if (s2.uncorr && (uncorr_count != {CNT_W{1'b1}}))
        uncorr_count <= uncorr_count + CNT_W'(1);
    end
  end

endmodule
